vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates pixel-clock-rate VGA raster timing for the sprite/palette drawing stages.
- Produces DrawX/DrawY coordinates and the blank (visible-region) flag that the sprite drawing blocks consume.
- Produces hs/vs sync outputs delayed by a parameterised number of cycles, so they line up with the registered ROM→palette→colour pipeline downstream.
- Also provides a frame-start strobe and a frame counter for game-logic animation.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, active level of hs/vs (0 = active-low)
- PIPE_DLY, 2, cycles of hs/vs delay matching downstream colour latency (0..7)

Ports:
- vga_clk  in  1  pixel clock (25 MHz for 640x480@60)
- reset_n  in  1  asynchronous active-low reset
- DrawX  out  10  current pixel column, 0..H_TOTAL-1
- DrawY  out  10  current line, 0..V_TOTAL-1
- blank  out  1  1 = (DrawX,DrawY) in visible region; 0 = blanking
- hs  out  1  horizontal sync, delayed PIPE_DLY cycles
- vs  out  1  vertical sync, delayed PIPE_DLY cycles
- frame_start  out  1  one-cycle strobe when raster wraps to (0,0)
- frame_count  out  8  frames completed since reset, wraps 255→0

Behaviour:
- Reset and clock: one clock (vga_clk). reset_n is asynchronous and active-low. All state resets immediately on reset_n low and is held while low.
- Derived constants: H_TOTAL = sum of H_* (800 default); V_TOTAL = sum of V_* (525 default). Both must be ≤1024; elaborate-time assertion otherwise.
- Reset values: DrawX=0, DrawY=0, blank=1, hs=~SYNC_ACTIVE, vs=~SYNC_ACTIVE, frame_start=0, frame_count=0. All delay-line stages reset to ~SYNC_ACTIVE.
- Horizontal counter (DrawX): increments by 1 every cycle. At H_TOTAL-1 it wraps to 0 and DrawY increments.
- Vertical counter (DrawY): at H_TOTAL-1 and V_TOTAL-1 both wrap to 0.
- Coordinate/blank alignment: DrawX, DrawY and blank are registers describing the same pixel in the same cycle. blank is computed from next-state counters: blank_next = (x_next < H_VISIBLE) && (y_next < V_VISIBLE).
- Raw sync decode (from current counters): hs_raw active when H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC. vs_raw active when V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC, for the whole line.
- Sync outputs: hs/vs equal hs_raw/vs_raw delayed exactly PIPE_DLY cycles. PIPE_DLY=0 is a pass-through of the decode; those outputs are combinational from the counter registers.
- frame_start: registered. It is 1 in exactly the cycle where DrawX=0, DrawY=0 following a wrap from (H_TOTAL-1, V_TOTAL-1); 0 otherwise. There is no frame_start pulse in the first cycle after reset release.
- frame_count: increments in the same cycle frame_start is 1. Modulo 256.
- Reset mid-frame: counters, frame_count and delay lines clear asynchronously. The raster restarts at (0,0) on the first vga_clk edge after release. No partial sync pulse is emitted after the reset edge.

Decomposition:
- Shared package vga_timing_pkg:
  - COORD_W=10.
  - Default 640x480@60 constants (H_*/V_* values, H_TOTAL=800, V_TOTAL=525).
  - Typedef coord_t = logic [COORD_W-1:0], used by the sprite drawing blocks.
- Sub-module sync_delay_line:
  - Parameters DEPTH and RESET_VAL.
  - 1-bit shift register with async active-low reset.
  - Instantiated twice, for hs and vs.

Test Plan:
- Reset: hold reset_n low 5 cycles, then release. Required: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, frame_count=0. DrawX=1 after the first edge.
- Line wrap: after 639 cycles DrawX=639, blank=1. Next cycle DrawX=640, blank=0. At DrawX=799 the next cycle gives DrawX=0, DrawY=1, blank=1.
- hs with PIPE_DLY=2: hs low from the cycle DrawX=658 through DrawX=753 inclusive (96 cycles), high elsewhere on every line.
- vs with PIPE_DLY=2: vs low from (DrawX=2, DrawY=490) for exactly 1600 cycles, ending at (DrawX=1, DrawY=492).
- Frame wrap: 420000 cycles after release gives DrawX=0, DrawY=0, frame_start=1 for one cycle, frame_count=1. After 256 frames, frame_count=0.
- Mid-frame reset: drive reset_n low at DrawY=300, DrawX=100. Required in the same cycle, asynchronously: all outputs at reset values. After release, hs stays 1 until DrawX=658.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster types and default 640x480@60 timing constants.
// Imported by the timing generator and by the sprite drawing blocks.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  typedef logic [COORD_W-1:0] coord_t;

  // Maps a decoded "in sync window" flag onto the physical pin level.
  function automatic logic sync_level(input logic active, input logic sync_active);
    return active ? sync_active : ~sync_active;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the drawing stages.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// 1-bit shift register used to align hs/vs with the downstream colour pipeline.
module sync_delay_line #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic dly
);

  if (DEPTH == 0) begin : g_pass
    // Zero depth is a plain wire; clock and reset are deliberately unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dly = raw;
  end else begin : g_shift
    logic [DEPTH-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg <= {DEPTH{RESET_VAL}};
      end else begin
        stage_reg[0] <= raw;
        for (int i = 1; i < DEPTH; i++) begin
          stage_reg[i] <= stage_reg[i-1];
        end
      end
    end

    assign dly = stage_reg[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, visible-region flag, pipeline-aligned syncs and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   PIPE_DLY    = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $fatal(1, "vga_timing_gen: PIPE_DLY must be within 0..7");
  end

  coord_t     x_reg, x_next;
  coord_t     y_reg, y_next;
  logic       blank_reg, blank_next;
  logic       frame_start_reg, frame_start_next;
  logic [7:0] frame_count_reg, frame_count_next;
  logic       x_wrap, y_wrap;
  logic       hs_raw, vs_raw;

  always_comb begin
    x_wrap = (x_reg == X_LAST);
    y_wrap = (y_reg == Y_LAST);
    x_next = x_wrap ? '0 : x_reg + coord_t'(1);
    y_next = y_reg;
    if (x_wrap) begin
      y_next = y_wrap ? '0 : y_reg + coord_t'(1);
    end
    // blank is decoded from the next coordinates so it stays aligned with DrawX/DrawY.
    blank_next       = (int'(x_next) < H_VISIBLE) && (int'(y_next) < V_VISIBLE);
    frame_start_next = x_wrap && y_wrap;
    frame_count_next = frame_count_reg + (frame_start_next ? 8'd1 : 8'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg           <= '0;
      y_reg           <= '0;
      blank_reg       <= 1'b1;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      blank_reg       <= blank_next;
      frame_start_reg <= frame_start_next;
      frame_count_reg <= frame_count_next;
    end
  end

  // Raw syncs come from the current counters; vs covers whole lines.
  always_comb begin
    hs_raw = sync_level((int'(x_reg) >= HS_START) && (int'(x_reg) < HS_END), SYNC_ACTIVE);
    vs_raw = sync_level((int'(y_reg) >= VS_START) && (int'(y_reg) < VS_END), SYNC_ACTIVE);
  end

  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (~SYNC_ACTIVE)
  ) u_hs_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .raw   (hs_raw),
    .dly   (vga.hs)
  );

  sync_delay_line #(
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (~SYNC_ACTIVE)
  ) u_vs_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .raw   (vs_raw),
    .dly   (vga.vs)
  );

  assign vga.DrawX       = x_reg;
  assign vga.DrawY       = y_reg;
  assign vga.blank       = blank_reg;
  assign vga.frame_start = frame_start_reg;
  assign vga.frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (15x10) so that
// 256 frames fit in a short run; a second instance covers PIPE_DLY=0, active-high sync.
module tb_vga_timing_gen;

  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 6, VF = 1, VSW = 2, VB = 1;
  localparam int D     = 2;
  localparam int H_T   = HV + HF + HSW + HB;
  localparam int V_T   = VV + VF + VSW + VB;
  localparam int HS0   = HV + HF;
  localparam int VS0   = VV + VF;
  localparam int FRAME = H_T * V_T;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fc;
    logic       hs0;
    logic       vs0;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   fail_prints = 0;
  obs_t exp_q[$];

  vga_timing_gen_if bus();
  vga_timing_gen_if bus0();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0), .PIPE_DLY(D)
  ) dut (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vga     (bus)
  );

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .SYNC_ACTIVE(1'b1), .PIPE_DLY(0)
  ) dut0 (
    .vga_clk (clk),
    .reset_n (reset_n),
    .vga     (bus0)
  );

  always #5 clk = ~clk;

  // Closed-form expectation after n clock edges since reset release.
  function automatic obs_t model(input int k);
    obs_t m;
    int x, y, xd, yd;
    x = k % H_T;
    y = (k / H_T) % V_T;
    m.x     = 10'(x);
    m.y     = 10'(y);
    m.blank = (x < HV) && (y < VV);
    if (k < D) begin
      m.hs = 1'b1;
      m.vs = 1'b1;
    end else begin
      xd   = (k - D) % H_T;
      yd   = ((k - D) / H_T) % V_T;
      m.hs = !((xd >= HS0) && (xd < HS0 + HSW));
      m.vs = !((yd >= VS0) && (yd < VS0 + VSW));
    end
    m.hs0 = (x >= HS0) && (x < HS0 + HSW);
    m.vs0 = (y >= VS0) && (y < VS0 + VSW);
    m.fs  = (k > 0) && (k % FRAME == 0);
    m.fc  = 8'((k / FRAME) % 256);
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.x     = bus.DrawX;
    s.y     = bus.DrawY;
    s.blank = bus.blank;
    s.hs    = bus.hs;
    s.vs    = bus.vs;
    s.fs    = bus.frame_start;
    s.fc    = bus.frame_count;
    s.hs0   = bus0.hs;
    s.vs0   = bus0.vs;
    return s;
  endfunction

  // Push the expectation for the coming edge, then wait for that edge.
  task automatic tick();
    if (reset_n) n++;
    exp_q.push_back(model(n));
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      tests_run++;
      if (g !== e) begin
        tests_failed++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL scoreboard t=%0t got x=%0d y=%0d b=%b hs=%b vs=%b fs=%b fc=%0d hs0=%b vs0=%b required x=%0d y=%0d b=%b hs=%b vs=%b fs=%b fc=%0d hs0=%b vs0=%b",
                   $time, g.x, g.y, g.blank, g.hs, g.vs, g.fs, g.fc, g.hs0, g.vs0,
                   e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc, e.hs0, e.vs0);
        end
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 5; i++) tick();
    #2;
    tests_run++;
    if ({bus.DrawX, bus.DrawY, bus.blank, bus.hs, bus.vs, bus.frame_start, bus.frame_count}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_state got x=%0d y=%0d b=%b hs=%b vs=%b fs=%b fc=%0d required 0 0 1 1 1 0 0",
               bus.DrawX, bus.DrawY, bus.blank, bus.hs, bus.vs, bus.frame_start, bus.frame_count);
    end
    reset_n = 1'b1;
    tick();
    #2;
    tests_run++;
    if (bus.DrawX !== 10'd1 || bus.frame_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_edge got x=%0d fs=%b required x=1 fs=0", bus.DrawX, bus.frame_start);
    end
  endtask

  task automatic test_line_wrap();
    while (n < HV - 1) tick();
    #2;
    tests_run++;
    if (bus.DrawX !== 10'(HV - 1) || bus.blank !== 1'b1) begin
      tests_failed++;
      $display("FAIL last_visible got x=%0d b=%b required x=%0d b=1", bus.DrawX, bus.blank, HV - 1);
    end
    tick();
    #2;
    tests_run++;
    if (bus.DrawX !== 10'(HV) || bus.blank !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_blank got x=%0d b=%b required x=%0d b=0", bus.DrawX, bus.blank, HV);
    end
    while (n < H_T) tick();
    #2;
    tests_run++;
    if (bus.DrawX !== 10'd0 || bus.DrawY !== 10'd1 || bus.blank !== 1'b1) begin
      tests_failed++;
      $display("FAIL line_wrap got x=%0d y=%0d b=%b required x=0 y=1 b=1", bus.DrawX, bus.DrawY, bus.blank);
    end
  endtask

  task automatic test_hsync();
    int cnt = 0;
    int first_x = -1;
    for (int i = 0; i < H_T; i++) begin
      #2;
      if (!bus.hs) begin
        cnt++;
        if (first_x < 0) first_x = int'(bus.DrawX);
      end
      tick();
    end
    tests_run++;
    if (cnt != HSW || first_x != HS0 + D) begin
      tests_failed++;
      $display("FAIL hsync_window got len=%0d start_x=%0d required len=%0d start_x=%0d", cnt, first_x, HSW, HS0 + D);
    end
  endtask

  task automatic test_frame_wrap();
    while (n < FRAME) tick();
    #2;
    tests_run++;
    if ({bus.DrawX, bus.DrawY, bus.frame_start, bus.frame_count} !== {10'd0, 10'd0, 1'b1, 8'd1}) begin
      tests_failed++;
      $display("FAIL frame_wrap got x=%0d y=%0d fs=%b fc=%0d required 0 0 1 1",
               bus.DrawX, bus.DrawY, bus.frame_start, bus.frame_count);
    end
    tick();
    #2;
    tests_run++;
    if (bus.frame_start !== 1'b0 || bus.frame_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL frame_strobe_width got fs=%b fc=%0d required fs=0 fc=1", bus.frame_start, bus.frame_count);
    end
  endtask

  task automatic test_vsync();
    int cnt = 0;
    int fx = -1, fy = -1, lx = -1, ly = -1;
    for (int i = 0; i < FRAME; i++) begin
      #2;
      if (!bus.vs) begin
        cnt++;
        if (fx < 0) begin
          fx = int'(bus.DrawX);
          fy = int'(bus.DrawY);
        end
        lx = int'(bus.DrawX);
        ly = int'(bus.DrawY);
      end
      tick();
    end
    tests_run++;
    if (cnt != VSW * H_T || fx != D || fy != VS0 || lx != D - 1 || ly != VS0 + VSW) begin
      tests_failed++;
      $display("FAIL vsync_window got len=%0d start=(%0d,%0d) end=(%0d,%0d) required len=%0d start=(%0d,%0d) end=(%0d,%0d)",
               cnt, fx, fy, lx, ly, VSW * H_T, D, VS0, D - 1, VS0 + VSW);
    end
  endtask

  task automatic test_mid_frame_reset();
    int target;
    bit early_low = 1'b0;
    // Stop inside the hsync window so the delay line holds an active sample.
    target = (n / FRAME) * FRAME + 4 * H_T + (HS0 + 1);
    if (target <= n) target += FRAME;
    while (n < target) tick();
    #2;
    tests_run++;
    if (bus.DrawX !== 10'(HS0 + 1) || bus.DrawY !== 10'd4 || bus.frame_count === 8'd0) begin
      tests_failed++;
      $display("FAIL pre_reset_pos got x=%0d y=%0d fc=%0d required x=%0d y=4 fc!=0",
               bus.DrawX, bus.DrawY, bus.frame_count, HS0 + 1);
    end
    reset_n = 1'b0;
    n = 0;
    #1;
    tests_run++;
    if ({bus.DrawX, bus.DrawY, bus.blank, bus.hs, bus.vs, bus.frame_start, bus.frame_count, bus0.hs, bus0.vs}
        !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset got x=%0d y=%0d b=%b hs=%b vs=%b fs=%b fc=%0d hs0=%b vs0=%b required 0 0 1 1 1 0 0 0 0",
               bus.DrawX, bus.DrawY, bus.blank, bus.hs, bus.vs, bus.frame_start, bus.frame_count, bus0.hs, bus0.vs);
    end
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset_n = 1'b1;
    for (int i = 1; i < HS0 + D; i++) begin
      tick();
      #2;
      if (!bus.hs) early_low = 1'b1;
    end
    tests_run++;
    if (early_low) begin
      tests_failed++;
      $display("FAIL no_partial_hsync got early hs low=1 required 0");
    end
    tick();
    #2;
    tests_run++;
    if (bus.hs !== 1'b0 || bus.DrawX !== 10'(HS0 + D)) begin
      tests_failed++;
      $display("FAIL hsync_after_reset got hs=%b x=%0d required hs=0 x=%0d", bus.hs, bus.DrawX, HS0 + D);
    end
  endtask

  task automatic test_frame_count_wrap();
    while (n < 256 * FRAME) tick();
    #2;
    tests_run++;
    if (bus.frame_count !== 8'd0 || bus.frame_start !== 1'b1 || bus.DrawX !== 10'd0 || bus.DrawY !== 10'd0) begin
      tests_failed++;
      $display("FAIL frame_count_wrap got fc=%0d fs=%b x=%0d y=%0d required fc=0 fs=1 x=0 y=0",
               bus.frame_count, bus.frame_start, bus.DrawX, bus.DrawY);
    end
    tick();
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    n = 0;
    test_reset();
    test_line_wrap();
    test_hsync();
    test_frame_wrap();
    test_vsync();
    test_mid_frame_reset();
    test_frame_count_wrap();
    #5;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
